// File: rtl/mode_ctrl_if.sv
// Button inputs and mode/strobe outputs of the mode sequencer.
// The design side uses the slave modport.
interface mode_ctrl_if;
    logic       btn_mode_i;
    logic       btn_set_i;
    logic       btn_rst_i;
    logic [2:0] state_o;
    logic       set_o;
    logic       mod_rst_o;
    logic       mode_chg_o;

    modport master (
        output btn_mode_i,
        output btn_set_i,
        output btn_rst_i,
        input  state_o,
        input  set_o,
        input  mod_rst_o,
        input  mode_chg_o
    );

    modport slave (
        input  btn_mode_i,
        input  btn_set_i,
        input  btn_rst_i,
        output state_o,
        output set_o,
        output mod_rst_o,
        output mode_chg_o
    );
endinterface

// File: rtl/mode_ctrl.sv
// Button front end: sync, debounce and edge detect per button,
// then a three-state mode FSM and prioritised set/reset strobes.
module mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    mode_ctrl_if.slave  bus
);
    localparam logic [2:0] ST_CNT = 3'b100;
    localparam logic [2:0] ST_WR  = 3'b010;
    localparam logic [2:0] ST_RD  = 3'b001;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 mode, bit 1 set, bit 2 module reset.
    logic [2:0]       btn;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       db_q;
    logic [2:0]       db_dly_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [2:0]       rise;

    logic [2:0]       state_q, state_d;
    logic             set_q, set_d;
    logic             mrst_q, mrst_d;
    logic             chg_q, chg_d;

    assign btn = {bus.btn_rst_i, bus.btn_set_i, bus.btn_mode_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            // Any return to the settled level restarts the count.
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    db_q[i]  <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = db_q & ~db_dly_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CNT:  if (rise[0]) state_d = ST_WR;
            ST_WR:   if (rise[0]) state_d = ST_RD;
            ST_RD:   if (rise[0]) state_d = ST_CNT;
            default: state_d = ST_CNT;
        endcase
        chg_d  = (state_d != state_q);
        // Mode edge wins over reset, reset wins over set.
        set_d  = rise[1] & ~rise[0] & ~rise[2];
        mrst_d = rise[2] & ~rise[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CNT;
            set_q   <= 1'b0;
            mrst_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            mrst_q  <= mrst_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.state_o    = state_q;
    assign bus.set_o      = set_q;
    assign bus.mod_rst_o  = mrst_q;
    assign bus.mode_chg_o = chg_q;
endmodule

// File: tb/tb_mode_ctrl.sv
// Directed plus random button stimulus for mode_ctrl, checked every
// cycle against a run-length button model and a mode index model.
module tb_mode_ctrl;
    localparam int D = 4;

    logic clk;
    logic rst_ni;

    mode_ctrl_if bus ();

    mode_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      tag, obs, exp, $time);
    endtask

    // Reference model state.
    logic [2:0] codes [3];
    logic [2:0] p0, p1;
    logic [2:0] mdb, mdb_prev;
    int         run [3];
    int         midx;
    logic       e_set, e_mrst, e_chg;
    int         n_set, n_mrst, n_chg;

    initial begin
        codes[0] = 3'b100;
        codes[1] = 3'b010;
        codes[2] = 3'b001;
    end

    task automatic model_reset();
        p0 = '0; p1 = '0;
        mdb = '0; mdb_prev = '0;
        for (int i = 0; i < 3; i++) run[i] = 0;
        midx = 0;
        e_set = 0; e_mrst = 0; e_chg = 0;
    endtask

    initial model_reset();

    task automatic cmp_all();
        chk("state", bus.state_o, codes[midx]);
        chk("set", bus.set_o, e_set);
        chk("mrst", bus.mod_rst_o, e_mrst);
        chk("mchg", bus.mode_chg_o, e_chg);
    endtask

    always @(negedge rst_ni) begin
        model_reset();
        #1 cmp_all();
    end

    always begin
        logic [2:0] raw, rise;
        @(posedge clk);
        raw = {bus.btn_rst_i, bus.btn_set_i, bus.btn_mode_i};
        if (rst_ni) begin
            rise   = mdb & ~mdb_prev;
            e_chg  = rise[0];
            e_set  = rise[1] && !rise[0] && !rise[2];
            e_mrst = rise[2] && !rise[0];
            if (rise[0]) midx = (midx + 1) % 3;
            mdb_prev = mdb;
            // Level flips after D consecutive disagreeing samples.
            for (int i = 0; i < 3; i++) begin
                if (p1[i] != mdb[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        mdb[i] = p1[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            p1 = p0;
            p0 = raw;
        end
        #1;
        cmp_all();
        if (bus.set_o === 1'b1) n_set++;
        if (bus.mod_rst_o === 1'b1) n_mrst++;
        if (bus.mode_chg_o === 1'b1) n_chg++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic btns(input logic m, input logic s, input logic r);
        bus.btn_mode_i = m;
        bus.btn_set_i  = s;
        bus.btn_rst_i  = r;
    endtask

    initial begin
        int b_set, b_mrst, b_chg;
        rst_ni = 1'b0;
        btns(0, 0, 0);
        step(3);
        rst_ni = 1'b1;

        step(20);
        chk("idle_state", bus.state_o, 3'b100);

        // Three mode presses, first one with explicit latency probe.
        b_chg = n_chg;
        btns(1, 0, 0);
        step(6);
        chk("lat_early", bus.mode_chg_o, 1'b0);
        step(1);
        chk("lat_7", bus.mode_chg_o, 1'b1);
        chk("lat_state", bus.state_o, 3'b010);
        step(3);
        btns(0, 0, 0);
        step(10);
        for (int k = 0; k < 2; k++) begin
            btns(1, 0, 0);
            step(10);
            btns(0, 0, 0);
            step(10);
        end
        chk("n_chg3", n_chg - b_chg, 3);
        chk("wrap_state", bus.state_o, 3'b100);

        // Bouncy set press.
        b_set = n_set;
        btns(0, 1, 0); step(1);
        btns(0, 0, 0); step(1);
        btns(0, 1, 0); step(1);
        btns(0, 0, 0); step(1);
        btns(0, 1, 0);
        step(6);
        chk("bnc_early", bus.set_o, 1'b0);
        step(1);
        chk("bnc_lat", bus.set_o, 1'b1);
        step(3);
        btns(0, 0, 0);
        step(12);
        chk("n_set_bnc", n_set - b_set, 1);

        // Set and reset together: reset wins.
        b_set = n_set; b_mrst = n_mrst;
        btns(0, 1, 1);
        step(10);
        btns(0, 0, 0);
        step(12);
        chk("sr_mrst", n_mrst - b_mrst, 1);
        chk("sr_set", n_set - b_set, 0);

        // Mode and set together: mode wins.
        b_set = n_set; b_chg = n_chg;
        btns(1, 1, 0);
        step(10);
        btns(0, 0, 0);
        step(12);
        chk("ms_chg", n_chg - b_chg, 1);
        chk("ms_set", n_set - b_set, 0);
        chk("ms_state", bus.state_o, 3'b010);

        // Reset in the middle of a set debounce.
        btns(0, 1, 0);
        step(3);
        #2 rst_ni = 1'b0;
        #2;
        chk("async_state", bus.state_o, 3'b100);
        step(2);
        rst_ni = 1'b1;
        b_set = n_set;
        step(6);
        chk("rr_early", bus.set_o, 1'b0);
        step(1);
        chk("rr_lat", bus.set_o, 1'b1);
        step(3);
        btns(0, 0, 0);
        step(12);
        chk("rr_nset", n_set - b_set, 1);

        // Long reset-button hold.
        b_mrst = n_mrst;
        btns(0, 0, 1);
        step(50);
        btns(0, 0, 0);
        step(12);
        chk("long_mrst", n_mrst - b_mrst, 1);
        chk("long_state", bus.state_o, 3'b100);

        // Random button activity.
        for (int k = 0; k < 80; k++) begin
            logic [2:0] r;
            r = 3'($urandom);
            btns(r[0], r[1], r[2]);
            step(int'($urandom_range(1, 8)));
        end
        btns(0, 0, 0);
        step(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
